// File: rtl/cpuf_pkg.sv
// rtl/cpuf_pkg.sv - shared opcodes, state encoding and control-word layout for the CPU sequencer
// Purpose: one place for opcode values, the 3-bit sequencer state encoding,
//          the wait-phase qualifier and the bit positions of the strobe vector.
// Ports:   none (package).
package cpuf_pkg;

  localparam logic [3:0] OP_LDA = 4'b1000;
  localparam logic [3:0] OP_LDB = 4'b0100;
  localparam logic [3:0] OP_ADD = 4'b0010;
  localparam logic [3:0] OP_SUB = 4'b0001;
  localparam logic [3:0] OP_JMP = 4'b1001;
  localparam logic [3:0] OP_WRT = 4'b1010;
  localparam logic [3:0] OP_HLT = 4'b1111;

  // Ten logical steps have to fit a 3-bit debug code, so every no-strobe
  // hold cycle (fetch wait, decode, execute wait) shares ST_WAIT and is told
  // apart by phase_t.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_ADDR   = 3'd2,
    ST_WAIT   = 3'd3,
    ST_LOADIR = 3'd4,
    ST_EXEC   = 3'd5,
    ST_RETIRE = 3'd6,
    ST_HALT   = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    PH_FWAIT  = 2'd0,
    PH_DECODE = 2'd1,
    PH_XWAIT  = 2'd2
  } phase_t;

  // Strobe vector bit positions.
  localparam int CW_PC   = 0;
  localparam int CW_MAR  = 1;
  localparam int CW_IR   = 2;
  localparam int CW_OUTA = 3;
  localparam int CW_OUTB = 4;
  localparam int CW_AD   = 5;
  localparam int CW_SB   = 6;
  localparam int CW_JMP  = 7;
  localparam int CW_ACC  = 8;
  localparam int CW_W    = 9;

  // Execute-cycle strobe for an opcode; unknown opcodes give no strobe (NOP).
  function automatic logic [CW_W-1:0] exec_cw(input logic [3:0] op);
    logic [CW_W-1:0] cw;
    cw = '0;
    case (op)
      OP_LDA:  cw[CW_OUTA] = 1'b1;
      OP_LDB:  cw[CW_OUTB] = 1'b1;
      OP_ADD:  cw[CW_AD]   = 1'b1;
      OP_SUB:  cw[CW_SB]   = 1'b1;
      OP_JMP:  cw[CW_JMP]  = 1'b1;
      OP_WRT:  cw[CW_ACC]  = 1'b1;
      default: cw = '0;
    endcase
    return cw;
  endfunction

  // Loads from RAM need the full read latency before the register settles.
  function automatic logic is_mem_op(input logic [3:0] op);
    return (op == OP_LDA) || (op == OP_LDB);
  endfunction

endpackage

// File: rtl/cpu_sequencer_if.sv
// rtl/cpu_sequencer_if.sv - control/strobe bundle between sequencer and datapath
// Purpose: groups run/step controls, the opcode and all sequencer outputs.
// Ports (master = sequencer side):
//   in : run, step_mode, step, ir_i[3:0]
//   out: pc_a, mar_a, ir_a, out_a, out_b, ad, sb, jmp, acc_out, halted,
//        state[2:0], icount[ICNT_W-1:0]
interface cpu_sequencer_if #(parameter int ICNT_W = 8);
  logic              run;
  logic              step_mode;
  logic              step;
  logic [3:0]        ir_i;
  logic              pc_a;
  logic              mar_a;
  logic              ir_a;
  logic              out_a;
  logic              out_b;
  logic              ad;
  logic              sb;
  logic              jmp;
  logic              acc_out;
  logic              halted;
  logic [2:0]        state;
  logic [ICNT_W-1:0] icount;

  modport master (
    input  run, step_mode, step, ir_i,
    output pc_a, mar_a, ir_a, out_a, out_b, ad, sb, jmp, acc_out,
           halted, state, icount
  );

  modport slave (
    output run, step_mode, step, ir_i,
    input  pc_a, mar_a, ir_a, out_a, out_b, ad, sb, jmp, acc_out,
           halted, state, icount
  );
endinterface

// File: rtl/seq_wait_timer.sv
// rtl/seq_wait_timer.sv - loadable down-counter used for sequencer wait states
// Purpose: holds a wait state for (load value + 1) cycles; o_done is high
//          whenever the count has reached zero.
// Ports: clk, rst (async high), i_load, i_load_val[W-1:0], o_done
module seq_wait_timer #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_load,
  input  logic [W-1:0] i_load_val,
  output logic         o_done
);

  logic [W-1:0] r_count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_val;
    end else if (r_count != '0) begin
      r_count <= r_count - 1'b1;
    end
  end

  assign o_done = (r_count == '0);

endmodule

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - explicit-state fetch/decode/execute sequencer for the CPU
// Purpose: drives single-cycle datapath strobes, inserts RAM wait states,
//          supports run/stop and single-step, reports halt and retired count.
// Ports: clk, reset (async high), bus (cpu_sequencer_if.master):
//   run, step_mode, step, ir_i in; strobes, halted, state, icount out.
module cpu_sequencer
  import cpuf_pkg::*;
#(
  parameter int RAM_LAT = 2,
  parameter int ICNT_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  cpu_sequencer_if.master  bus
);

  // Timer counts down to zero, so a wait of N cycles loads N-1.
  localparam logic [2:0] LAT_M1 = 3'(RAM_LAT - 1);

  state_t            r_state, w_next;
  phase_t            r_phase, w_phase_next;
  logic [3:0]        r_op, w_op;
  logic [CW_W-1:0]   r_cw, w_cw;
  logic              r_halted;
  logic [ICNT_W-1:0] r_icount;
  logic              w_load;
  logic [2:0]        w_load_val;
  logic              w_done;

  seq_wait_timer #(.W(3)) u_timer (
    .clk        (clk),
    .rst        (reset),
    .i_load     (w_load),
    .i_load_val (w_load_val),
    .o_done     (w_done)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= ST_IDLE;
      r_phase  <= PH_FWAIT;
      r_op     <= '0;
      r_cw     <= '0;
      r_halted <= 1'b0;
      r_icount <= '0;
    end else begin
      r_state  <= w_next;
      r_phase  <= w_phase_next;
      r_op     <= w_op;
      // Strobes are decoded from the next state so they line up with it.
      r_cw     <= w_cw;
      r_halted <= r_halted | (w_next == ST_HALT);
      if (r_state == ST_RETIRE) begin
        r_icount <= r_icount + 1'b1;
      end
    end
  end

  always_comb begin
    w_next       = r_state;
    w_phase_next = r_phase;
    w_op         = r_op;
    w_load       = 1'b0;
    w_load_val   = '0;
    w_cw         = '0;

    case (r_state)
      ST_IDLE: begin
        // A step pulse only counts here; pulses seen elsewhere are dropped.
        if (bus.run && (!bus.step_mode || bus.step)) begin
          w_next = ST_FETCH;
        end
      end
      ST_FETCH: w_next = ST_ADDR;
      ST_ADDR: begin
        w_next       = ST_WAIT;
        w_phase_next = PH_FWAIT;
        w_load       = 1'b1;
        w_load_val   = LAT_M1;
      end
      ST_LOADIR: begin
        w_next       = ST_WAIT;
        w_phase_next = PH_DECODE;
        w_load       = 1'b1;
        w_load_val   = 3'd0;
      end
      ST_WAIT: begin
        if (w_done) begin
          case (r_phase)
            PH_FWAIT:  w_next = ST_LOADIR;
            PH_DECODE: begin
              // IR is valid during decode; capture it for the execute half.
              w_op   = bus.ir_i;
              w_next = (bus.ir_i == OP_HLT) ? ST_HALT : ST_EXEC;
            end
            default:   w_next = ST_RETIRE;
          endcase
        end
      end
      ST_EXEC: begin
        w_next       = ST_WAIT;
        w_phase_next = PH_XWAIT;
        w_load       = 1'b1;
        w_load_val   = is_mem_op(r_op) ? LAT_M1 : 3'd0;
      end
      ST_RETIRE: w_next = ST_IDLE;
      ST_HALT:   w_next = ST_HALT;
      default:   w_next = ST_IDLE;
    endcase

    case (w_next)
      ST_FETCH:  w_cw[CW_PC]  = 1'b1;
      ST_ADDR:   w_cw[CW_MAR] = 1'b1;
      ST_LOADIR: w_cw[CW_IR]  = 1'b1;
      ST_EXEC:   w_cw         = exec_cw(w_op);
      default:   w_cw         = '0;
    endcase
  end

  assign bus.pc_a    = r_cw[CW_PC];
  assign bus.mar_a   = r_cw[CW_MAR];
  assign bus.ir_a    = r_cw[CW_IR];
  assign bus.out_a   = r_cw[CW_OUTA];
  assign bus.out_b   = r_cw[CW_OUTB];
  assign bus.ad      = r_cw[CW_AD];
  assign bus.sb      = r_cw[CW_SB];
  assign bus.jmp     = r_cw[CW_JMP];
  assign bus.acc_out = r_cw[CW_ACC];
  assign bus.halted  = r_halted;
  assign bus.state   = r_state;
  assign bus.icount  = r_icount;

endmodule
